// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: merges NUM_CHANNELS credit-flow-controlled flit streams into one
// router local port using per-channel FIFOs, wormhole packet locking and downstream credit tracking.
module noc_inject_arbiter #(
  parameter int unsigned NUM_CHANNELS      = 4,
  parameter int unsigned FLIT_WIDTH        = 128,
  parameter int unsigned DEST_WIDTH        = 6,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8,
  parameter int unsigned OUT_CREDITS       = 8,
  parameter int unsigned ARB_MODE          = 0
) (
  input  logic                                    clk_noc,
  input  logic                                    rst_n,
  input  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] data_in,
  input  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] dest_in,
  input  logic [NUM_CHANNELS-1:0]                 is_tail_in,
  input  logic [NUM_CHANNELS-1:0]                 send_in,
  output logic [NUM_CHANNELS-1:0]                 credit_out,
  output logic [FLIT_WIDTH-1:0]                   data_out,
  output logic [DEST_WIDTH-1:0]                   dest_out,
  output logic                                    is_tail_out,
  output logic                                    send_out,
  input  logic                                    credit_in,
  output logic [$clog2(OUT_CREDITS+1)-1:0]        credit_count,
  output logic [NUM_CHANNELS-1:0]                 err_overflow
);

  localparam int unsigned CH_W  = $clog2(NUM_CHANNELS);
  localparam int unsigned AW    = $clog2(FLIT_BUFFER_DEPTH);
  localparam int unsigned CC_W  = $clog2(OUT_CREDITS + 1);
  localparam int unsigned ENT_W = FLIT_WIDTH + DEST_WIDTH + 1;

  typedef logic [ENT_W-1:0] entry_t;
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

  entry_t                         mem_q [NUM_CHANNELS][FLIT_BUFFER_DEPTH];
  logic [NUM_CHANNELS-1:0][AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_CHANNELS-1:0]        empty, full, elig, push, pop, ovf;

  lock_state_t                    lock_q, lock_d;
  logic [CH_W-1:0]                lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [CC_W-1:0]                credit_count_q, credit_count_d;
  logic [FLIT_WIDTH-1:0]          data_q, data_d;
  logic [DEST_WIDTH-1:0]          dest_q, dest_d;
  logic                           tail_q, tail_d;
  logic                           send_q, send_d;
  logic [NUM_CHANNELS-1:0]        credit_out_q, credit_out_d;
  logic [NUM_CHANNELS-1:0]        err_q, err_d;

  logic                           grant_valid;
  logic [CH_W-1:0]                grant_ch;
  logic [CH_W:0]                  cand_sum;
  entry_t                         head_sel;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                 (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      elig[c]  = !empty[c] && (credit_count_q != '0);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand_sum    = '0;
    if (lock_q == ST_LOCKED) begin
      grant_valid = elig[lock_ch_q];
      grant_ch    = lock_ch_q;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (ARB_MODE == 0) begin
          cand_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
          if (cand_sum >= (CH_W+1)'(NUM_CHANNELS))
            cand_sum = cand_sum - (CH_W+1)'(NUM_CHANNELS);
        end else begin
          cand_sum = (CH_W+1)'(i);
        end
        if (!grant_valid && elig[cand_sum[CH_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_ch    = cand_sum[CH_W-1:0];
        end
      end
    end
  end

  assign head_sel = mem_q[grant_ch][rd_ptr_q[grant_ch][AW-1:0]];

  // A write into a full FIFO is accepted when the same FIFO pops on that edge.
  always_comb begin
    pop = '0;
    if (grant_valid) pop[grant_ch] = 1'b1;
    push = send_in & (~full | pop);
    ovf  = send_in & full & ~pop;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + (AW+1)'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + (AW+1)'(pop[c]);
    end
  end

  always_comb begin
    lock_d         = lock_q;
    lock_ch_d      = lock_ch_q;
    rr_ptr_d       = rr_ptr_q;
    data_d         = data_q;
    dest_d         = dest_q;
    tail_d         = tail_q;
    send_d         = grant_valid;
    credit_out_d   = pop;
    err_d          = err_q | ovf;
    credit_count_d = credit_count_q;
    if (grant_valid) begin
      data_d = head_sel[FLIT_WIDTH-1:0];
      dest_d = head_sel[FLIT_WIDTH +: DEST_WIDTH];
      tail_d = head_sel[ENT_W-1];
      if (head_sel[ENT_W-1]) begin
        lock_d = ST_OPEN;
        if (ARB_MODE == 0)
          rr_ptr_d = (grant_ch == CH_W'(NUM_CHANNELS-1)) ? '0 : grant_ch + CH_W'(1);
      end else begin
        lock_d    = ST_LOCKED;
        lock_ch_d = grant_ch;
      end
    end
    case ({grant_valid, credit_in})
      2'b10:   credit_count_d = credit_count_q - CC_W'(1);
      2'b01:   if (credit_count_q != CC_W'(OUT_CREDITS)) credit_count_d = credit_count_q + CC_W'(1);
      default: credit_count_d = credit_count_q;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c][AW-1:0]] <= {is_tail_in[c], dest_in[c], data_in[c]};
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      lock_q         <= ST_OPEN;
      lock_ch_q      <= '0;
      rr_ptr_q       <= '0;
      credit_count_q <= CC_W'(OUT_CREDITS);
      data_q         <= '0;
      dest_q         <= '0;
      tail_q         <= 1'b0;
      send_q         <= 1'b0;
      credit_out_q   <= '0;
      err_q          <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      lock_q         <= lock_d;
      lock_ch_q      <= lock_ch_d;
      rr_ptr_q       <= rr_ptr_d;
      credit_count_q <= credit_count_d;
      data_q         <= data_d;
      dest_q         <= dest_d;
      tail_q         <= tail_d;
      send_q         <= send_d;
      credit_out_q   <= credit_out_d;
      err_q          <= err_d;
    end
  end

  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign send_out     = send_q;
  assign credit_out   = credit_out_q;
  assign credit_count = credit_count_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: one round-robin and one fixed-priority instance
// share the input stimulus; each step checks outputs against hand-computed values.
module tb_noc_inject_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned FW = 128;
  localparam int unsigned DW = 6;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NC-1:0][FW-1:0] data_in;
  logic [NC-1:0][DW-1:0] dest_in;
  logic [NC-1:0]         is_tail_in, send_in;
  logic                  credit_in;

  logic [NC-1:0] rr_credit_out, rr_err, fp_credit_out, fp_err;
  logic [FW-1:0] rr_data, fp_data;
  logic [DW-1:0] rr_dest, fp_dest;
  logic          rr_tail, rr_send, fp_tail, fp_send;
  logic [3:0]    rr_cc, fp_cc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  noc_inject_arbiter #(
    .NUM_CHANNELS(NC), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .FLIT_BUFFER_DEPTH(8), .OUT_CREDITS(8), .ARB_MODE(0)
  ) u_rr (
    .clk_noc(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(rr_credit_out),
    .data_out(rr_data), .dest_out(rr_dest), .is_tail_out(rr_tail), .send_out(rr_send),
    .credit_in(credit_in), .credit_count(rr_cc), .err_overflow(rr_err)
  );

  noc_inject_arbiter #(
    .NUM_CHANNELS(NC), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .FLIT_BUFFER_DEPTH(8), .OUT_CREDITS(8), .ARB_MODE(1)
  ) u_fp (
    .clk_noc(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(fp_credit_out),
    .data_out(fp_data), .dest_out(fp_dest), .is_tail_out(fp_tail), .send_out(fp_send),
    .credit_in(credit_in), .credit_count(fp_cc), .err_overflow(fp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    data_in    = '0;
    dest_in    = '0;
    is_tail_in = '0;
    send_in    = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    credit_in = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int sends;
    logic [127:0] last_data;
    sends     = 0;
    last_data = '0;

    // Reset values
    rst_n     = 1'b0;
    credit_in = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("rst_send", rr_send, 0);
    check("rst_data", rr_data, 0);
    check("rst_dest", rr_dest, 0);
    check("rst_tail", rr_tail, 0);
    check("rst_credit_out", rr_credit_out, 0);
    check("rst_credit_count", rr_cc, 8);
    check("rst_err", rr_err, 0);
    check("rst_fp_credit_count", fp_cc, 8);
    check("rst_fp_dest", fp_dest, 0);
    check("rst_fp_err", fp_err, 0);
    rst_n = 1'b1;

    // credit_in at full count saturates
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("sat_credit_count", rr_cc, 8);

    // Single flit on ch1: latency 2
    send_in[1] = 1'b1; dest_in[1] = 6'h05; is_tail_in[1] = 1'b1; data_in[1] = 128'hA5;
    tick();
    clear_inputs();
    check("t1_send_t1", rr_send, 0);
    tick();
    check("t1_send_t2", rr_send, 1);
    check("t1_dest", rr_dest, 6'h05);
    check("t1_data", rr_data, 128'hA5);
    check("t1_tail", rr_tail, 1);
    check("t1_credit_out", rr_credit_out, 4'b0010);
    check("t1_credit_count", rr_cc, 7);
    tick();
    check("t1_send_t3", rr_send, 0);
    check("t1_credit_out_t3", rr_credit_out, 0);
    check("t1_data_hold", rr_data, 128'hA5);

    // Mode 0: ch0 and ch2 three-flit packets queued together, no interleave
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        check("t2_send", rr_send, 1);
        check("t2_data", rr_data, (k < 5) ? 128'(k - 2) : 128'(32 + k - 5));
        check("t2_tail", rr_tail, (k == 4 || k == 7));
        check("t2_dest", rr_dest, (k < 5) ? 6'd1 : 6'd3);
      end else begin
        check("t2_idle", rr_send, 0);
      end
      clear_inputs();
      if (k < 3) begin
        send_in       = 4'b0101;
        data_in[0]    = 128'(k);
        data_in[2]    = 128'(32 + k);
        is_tail_in[0] = (k == 2);
        is_tail_in[2] = (k == 2);
        dest_in[0]    = 6'd1;
        dest_in[2]    = 6'd3;
      end
      tick();
    end
    check("t2_done_send", rr_send, 0);
    check("t2_credit_count", rr_cc, 2);

    // Mode 0: pointer now at ch3, so ch3 wins over ch0
    send_in = 4'b1001; data_in[0] = 128'hC0; data_in[3] = 128'hC3; is_tail_in = 4'b1001;
    tick();
    clear_inputs();
    tick();
    check("rr_first", rr_data, 128'hC3);
    tick();
    check("rr_second", rr_data, 128'hC0);
    check("rr_credit_count", rr_cc, 0);

    // Credit exhaustion: 10 flits, 8 delivered
    do_reset();
    sends = 0;
    for (int k = 0; k < 14; k++) begin
      if (rr_send) sends++;
      clear_inputs();
      if (k < 10) begin
        send_in[1] = 1'b1; is_tail_in[1] = 1'b1; data_in[1] = 128'(k);
      end
      tick();
    end
    check("t3_sends", sends, 8);
    check("t3_credit_zero", rr_cc, 0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    sends = 0;
    for (int k = 0; k < 6; k++) begin
      if (rr_send) begin
        sends++;
        last_data = rr_data;
      end
      tick();
    end
    check("t3_one_more", sends, 1);
    check("t3_one_more_data", last_data, 8);
    check("t3_credit_end", rr_cc, 0);

    // Mode 1: ch3 mid-packet keeps the lock while ch0 waits
    do_reset();
    send_in[3] = 1'b1; data_in[3] = 128'h30; is_tail_in[3] = 1'b0;
    tick();
    check("t4_send_t1", fp_send, 0);
    clear_inputs();
    send_in[0] = 1'b1; data_in[0] = 128'h0A; is_tail_in[0] = 1'b1;
    tick();
    check("t4_head_send", fp_send, 1);
    check("t4_head_data", fp_data, 128'h30);
    clear_inputs();
    tick();
    check("t4_locked_stall", fp_send, 0);
    send_in[3] = 1'b1; data_in[3] = 128'h31; is_tail_in[3] = 1'b1;
    tick();
    clear_inputs();
    check("t4_stall2", fp_send, 0);
    tick();
    check("t4_tail_send", fp_send, 1);
    check("t4_tail_data", fp_data, 128'h31);
    check("t4_tail_flag", fp_tail, 1);
    check("t4_tail_credit", fp_credit_out, 4'b1000);
    tick();
    check("t4_ch0_send", fp_send, 1);
    check("t4_ch0_data", fp_data, 128'h0A);
    check("t4_ch0_credit", fp_credit_out, 4'b0001);
    send_in = 4'b0110; data_in[1] = 128'h11; data_in[2] = 128'h22; is_tail_in = 4'b0110;
    tick();
    clear_inputs();
    check("t4_prio_idle", fp_send, 0);
    tick();
    check("t4_prio_first", fp_data, 128'h11);
    tick();
    check("t4_prio_second", fp_data, 128'h22);

    // Overflow at zero credits, then restore credits
    do_reset();
    for (int k = 0; k < 10; k++) begin
      clear_inputs();
      if (k < 8) begin
        send_in[0] = 1'b1; is_tail_in[0] = 1'b1; data_in[0] = 128'(k);
      end
      tick();
    end
    clear_inputs();
    check("t5_drained", rr_cc, 0);
    sends = 0;
    for (int k = 0; k < 9; k++) begin
      if (rr_send) sends++;
      clear_inputs();
      send_in[2] = 1'b1; is_tail_in[2] = 1'b1; data_in[2] = 128'(64 + k);
      tick();
    end
    clear_inputs();
    check("t5_no_send", sends, 0);
    check("t5_err", rr_err, 4'b0100);
    sends = 0;
    for (int k = 0; k < 14; k++) begin
      if (rr_send) begin
        sends++;
        last_data = rr_data;
      end
      credit_in = (k < 8);
      tick();
    end
    credit_in = 1'b0;
    check("t5_delivered", sends, 8);
    check("t5_last_data", last_data, 128'h47);
    check("t5_credit_end", rr_cc, 0);
    check("t5_err_sticky", rr_err, 4'b0100);

    // Reset mid-packet
    do_reset();
    send_in[1] = 1'b1; data_in[1] = 128'h51; is_tail_in[1] = 1'b0;
    tick();
    clear_inputs();
    send_in[1] = 1'b1; data_in[1] = 128'h52; is_tail_in[1] = 1'b0;
    tick();
    clear_inputs();
    check("t6_pre_send", rr_send, 1);
    check("t6_pre_data", rr_data, 128'h51);
    rst_n = 1'b0;
    tick();
    check("t6_rst_send", rr_send, 0);
    check("t6_rst_data", rr_data, 0);
    check("t6_rst_dest", rr_dest, 0);
    check("t6_rst_tail", rr_tail, 0);
    check("t6_rst_credit_out", rr_credit_out, 0);
    check("t6_rst_credit_count", rr_cc, 8);
    rst_n = 1'b1;
    send_in[2] = 1'b1; data_in[2] = 128'h77; dest_in[2] = 6'h2A; is_tail_in[2] = 1'b1;
    tick();
    clear_inputs();
    check("t6_no_stale", rr_send, 0);
    tick();
    check("t6_new_send", rr_send, 1);
    check("t6_new_data", rr_data, 128'h77);
    check("t6_new_dest", rr_dest, 6'h2A);
    check("t6_new_credit_out", rr_credit_out, 4'b0100);
    check("t6_new_credit_count", rr_cc, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
